regfile_writer: RTL

Write-side front end for the 64-bit integer register file. It accepts completed results from the ALU and the load unit over valid/ready handshakes and buffers them. It arbitrates them round-robin onto the single regfile write port (`we`/`wa`/`wd`). It also exports a hazard query so decode can stall on a source register that still has a write in flight.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/regfile_writer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register-file write front end.
package regfile_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

    // Which source received the most recent write-port grant.
    typedef enum logic {
        SrcAlu = 1'b0,
        SrcMem = 1'b1
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO for load results; exposes per-entry rd/valid for hazard checks.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int unsigned DW    = 64,
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic [AW-1:0]              i_push_rd,
    input  logic [DW-1:0]              i_push_data,
    input  logic                       i_pop,
    output logic [AW-1:0]              o_head_rd,
    output logic [DW-1:0]              o_head_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [DEPTH-1:0][AW-1:0]   o_rd_vec,
    output logic [DEPTH-1:0]           o_vld_vec
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    logic [PW-1:0]             r_wptr;
    logic [PW-1:0]             r_rptr;
    logic [DEPTH-1:0][AW-1:0]  r_rd;
    logic [DEPTH-1:0][DW-1:0]  r_data;
    logic [DEPTH-1:0]          r_vld;
    logic [DEPTH-1:0]          w_vld_nxt;
    logic                      w_wr;
    logic                      w_rd;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign o_full  = (r_wptr[IW] != r_rptr[IW]) && (r_wptr[IW-1:0] == r_rptr[IW-1:0]);
    assign o_empty = (r_wptr == r_rptr);

    assign w_wr = i_push && !o_full;
    assign w_rd = i_pop && !o_empty;

    assign o_head_rd   = r_rd[r_rptr[IW-1:0]];
    assign o_head_data = r_data[r_rptr[IW-1:0]];
    assign o_rd_vec    = r_rd;
    assign o_vld_vec   = r_vld;

    always_comb begin
        w_vld_nxt = r_vld;
        if (w_wr) begin
            w_vld_nxt[r_wptr[IW-1:0]] = 1'b1;
        end
        if (w_rd) begin
            w_vld_nxt[r_rptr[IW-1:0]] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_vld  <= '0;
        end else begin
            r_vld <= w_vld_nxt;
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_rd) begin
                r_rptr <= r_rptr + PW'(1);
            end
        end
    end

    // Storage needs no reset: r_vld qualifies every read of it.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_rd[r_wptr[IW-1:0]]   <= i_push_rd;
            r_data[r_wptr[IW-1:0]] <= i_push_data;
        end
    end

endmodule

// File: rtl/regfile_writer.sv
// Write-side front end of the integer regfile: buffers ALU and load results, arbitrates
// them round-robin onto the single write port, and reports in-flight writes to decode.
module regfile_writer #(
    parameter int unsigned XLEN   = regfile_pkg::XLEN,
    parameter int unsigned AW     = regfile_pkg::REG_AW,
    parameter int unsigned MDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    input  logic [AW-1:0]   alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,
    input  logic            mem_valid,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    output logic            mem_ready,
    output logic            we,
    output logic [AW-1:0]   wa,
    output logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   hz_ra,
    output logic            hz_hit
);

    localparam logic [AW-1:0] RdZero = AW'(regfile_pkg::REG_ZERO);

    logic                       r_alu_vld;
    logic [AW-1:0]              r_alu_rd;
    logic [XLEN-1:0]            r_alu_data;
    logic                       w_alu_vld_nxt;
    regfile_pkg::wb_src_e       r_last;
    regfile_pkg::wb_src_e       w_last_nxt;
    logic                       r_we;
    logic [AW-1:0]              r_wa;
    logic [XLEN-1:0]            r_wd;
    logic                       w_we_nxt;
    logic [AW-1:0]              w_wa_nxt;
    logic [XLEN-1:0]            w_wd_nxt;

    logic                       w_alu_push;
    logic                       w_mem_push;
    logic                       w_gnt_alu;
    logic                       w_gnt_mem;
    logic                       w_mem_full;
    logic                       w_mem_empty;
    logic [AW-1:0]              w_mem_head_rd;
    logic [XLEN-1:0]            w_mem_head_data;
    logic [MDEPTH-1:0][AW-1:0]  w_fifo_rd;
    logic [MDEPTH-1:0]          w_fifo_vld;
    logic                       w_fifo_hit;

    // Writes to x0 are acknowledged but never buffered.
    assign w_alu_push = alu_valid && alu_ready && (alu_rd != RdZero);
    assign w_mem_push = mem_valid && mem_ready && (mem_rd != RdZero);

    assign alu_ready = !r_alu_vld || w_gnt_alu;
    assign mem_ready = !w_mem_full;

    wb_fifo #(
        .DW    (XLEN),
        .AW    (AW),
        .DEPTH (MDEPTH)
    ) u_wb_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_mem_push),
        .i_push_rd   (mem_rd),
        .i_push_data (mem_data),
        .i_pop       (w_gnt_mem),
        .o_head_rd   (w_mem_head_rd),
        .o_head_data (w_mem_head_data),
        .o_full      (w_mem_full),
        .o_empty     (w_mem_empty),
        .o_rd_vec    (w_fifo_rd),
        .o_vld_vec   (w_fifo_vld)
    );

    // Round-robin: on contention the source that did not win last time is granted.
    always_comb begin
        w_gnt_alu  = 1'b0;
        w_gnt_mem  = 1'b0;
        w_last_nxt = r_last;
        if (r_alu_vld && (w_mem_empty || r_last == regfile_pkg::SrcMem)) begin
            w_gnt_alu  = 1'b1;
            w_last_nxt = regfile_pkg::SrcAlu;
        end else if (!w_mem_empty) begin
            w_gnt_mem  = 1'b1;
            w_last_nxt = regfile_pkg::SrcMem;
        end
    end

    always_comb begin
        w_alu_vld_nxt = r_alu_vld;
        if (w_gnt_alu) begin
            w_alu_vld_nxt = 1'b0;
        end
        if (w_alu_push) begin
            w_alu_vld_nxt = 1'b1;
        end
    end

    always_comb begin
        w_we_nxt = w_gnt_alu || w_gnt_mem;
        w_wa_nxt = r_wa;
        w_wd_nxt = r_wd;
        if (w_gnt_alu) begin
            w_wa_nxt = r_alu_rd;
            w_wd_nxt = r_alu_data;
        end else if (w_gnt_mem) begin
            w_wa_nxt = w_mem_head_rd;
            w_wd_nxt = w_mem_head_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_vld  <= 1'b0;
            r_alu_rd   <= '0;
            r_alu_data <= '0;
            r_last     <= regfile_pkg::SrcAlu;
            r_we       <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
        end else begin
            r_alu_vld <= w_alu_vld_nxt;
            r_last    <= w_last_nxt;
            r_we      <= w_we_nxt;
            r_wa      <= w_wa_nxt;
            r_wd      <= w_wd_nxt;
            if (w_alu_push) begin
                r_alu_rd   <= alu_rd;
                r_alu_data <= alu_data;
            end
        end
    end

    assign we = r_we;
    assign wa = r_wa;
    assign wd = r_wd;

    always_comb begin
        w_fifo_hit = 1'b0;
        for (int unsigned i = 0; i < MDEPTH; i++) begin
            if (w_fifo_vld[i] && (w_fifo_rd[i] == hz_ra)) begin
                w_fifo_hit = 1'b1;
            end
        end
    end

    // The regfile has no write-to-read bypass, so the output register is still pending.
    assign hz_hit = (hz_ra != RdZero) &&
                    ((r_alu_vld && (r_alu_rd == hz_ra)) || w_fifo_hit || (r_we && (r_wa == hz_ra)));

endmodule
